// File: rtl/ws_cnn_pkg.sv
// Shared types and constants for the CNN window path.
// Holds the pixel type, default image geometry, the window-generator
// state encoding and the window bus index helper.
package ws_cnn_pkg;

  // Pixel width and default image geometry
  localparam int PIX_W     = 8;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_IMG_H = 32;

  // Width of the column / row-triplet counters and index outputs
  localparam int CNT_W = 5;

  // Window geometry
  localparam int WIN_DIM  = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

  // Signed two's complement pixel
  typedef logic signed [PIX_W-1:0] pixel_t;

  // Window generator sequencing
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } win_state_t;

  // LSB position of tap (r, c) on the flattened window bus.
  // r0 is the x1 (top) row, c0 the oldest column.
  function automatic int win_lsb(input int r, input int c, input int w);
    return (r * WIN_DIM + c) * w;
  endfunction

endpackage

// File: rtl/win_col_shift.sv
// 3-deep x 3-row pixel shift register feeding the window bus.
// Tap 0 holds the oldest column, tap 2 the newest. A shift either loads the
// incoming column or, with i_zero set, a column of zeros (used for the
// right-hand padding column).
module win_col_shift
  import ws_cnn_pkg::*;
#(
  parameter int DATA_W = PIX_W
) (
  input  logic                            sys_clk,
  input  logic                            rst,
  input  logic                            i_shift,
  input  logic                            i_zero,
  input  logic [WIN_DIM*DATA_W-1:0]       i_col,
  output logic [WIN_TAPS*DATA_W-1:0]      o_win
);

  genvar gi, gj;

  generate
    for (gi = 0; gi < WIN_DIM; gi++) begin : g_row
      logic [DATA_W-1:0] r_tap [WIN_DIM];
      logic [DATA_W-1:0] w_new;

      assign w_new = i_zero ? '0 : i_col[gi*DATA_W +: DATA_W];

      // Age this row by one column; the newest tap takes the incoming pixel
      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < WIN_DIM; k++) begin
            r_tap[k] <= '0;
          end
        end else if (i_shift) begin
          for (int k = 0; k < WIN_DIM-1; k++) begin
            r_tap[k] <= r_tap[k+1];
          end
          r_tap[WIN_DIM-1] <= w_new;
        end
      end

      for (gj = 0; gj < WIN_DIM; gj++) begin : g_col
        assign o_win[win_lsb(gi, gj, DATA_W) +: DATA_W] = r_tap[gj];
      end
    end
  endgenerate

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator placed after the image row buffer.
// Accepts one three-pixel column per beat and presents one 3x3 window per
// beat, tagged with column and row-triplet position; pulses frame_done when
// the last window of a frame is taken.
// Build option: define WIN_ZERO_PAD_EN for 'same' horizontal padding (a zero
// column on each side of every row, IMG_W windows per row). Without it the
// generator runs in 'valid' mode (IMG_W-2 windows per row).
module conv_window_gen
  import ws_cnn_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          x1,
  input  logic [DATA_W-1:0]          x2,
  input  logic [DATA_W-1:0]          x3,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [WIN_TAPS*DATA_W-1:0] win,
  output logic [CNT_W-1:0]           col_idx,
  output logic [CNT_W-1:0]           row_idx,
  output logic                       frame_done
);

  // Last column of a row and last row triplet of a frame
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 3);

  win_state_t        r_state;
  logic [CNT_W-1:0]  r_col_cnt;
  logic [CNT_W-1:0]  r_row_cnt;
  logic              r_win_valid;
  logic [CNT_W-1:0]  r_col_idx;
  logic [CNT_W-1:0]  r_row_idx;

  logic              w_room;
  logic              w_pad;
  logic              w_accept;
  logic              w_pad_beat;
  logic              w_consume;
  logic              w_shift;
  logic [WIN_DIM*DATA_W-1:0] w_col;

`ifdef WIN_ZERO_PAD_EN
  // With a zero column ahead of column 0, the first full window exists
  // after the second accepted column; col_idx then names the centre column.
  localparam logic [CNT_W-1:0] FIRST_COL = CNT_W'(1);

  logic r_pad_inject;

  assign w_pad = r_pad_inject;

  // Schedule one zero-column beat after the last real column of each row
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_pad_inject <= 1'b0;
    end else if (w_accept && (r_col_cnt == LAST_COL)) begin
      r_pad_inject <= 1'b1;
    end else if (w_pad_beat) begin
      r_pad_inject <= 1'b0;
    end
  end
`else
  // Without padding a window needs three real columns
  localparam logic [CNT_W-1:0] FIRST_COL = CNT_W'(2);

  assign w_pad = 1'b0;
`endif

  // The window register may be overwritten when empty or being consumed
  assign w_room     = !r_win_valid || win_ready;
  assign in_ready   = en && !rst && (r_state != DRAIN) && w_room && !w_pad;
  assign w_accept   = in_valid && in_ready;
  assign w_pad_beat = en && !rst && w_pad && w_room;
  assign w_consume  = r_win_valid && win_ready;
  assign w_shift    = w_accept || w_pad_beat;

  // Last window leaves while draining: no pending pad column, so this
  // handshake is the final one of the frame.
  assign frame_done = en && !rst && (r_state == DRAIN) && r_win_valid &&
                      win_ready && !w_pad;

  assign w_col = {x3, x2, x1};

  win_col_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .sys_clk (sys_clk),
    .rst     (rst),
    .i_shift (w_shift),
    .i_zero  (w_pad_beat),
    .i_col   (w_col),
    .o_win   (win)
  );

  // Sequencing: column/row counters, window valid flag and position tags
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_win_valid <= 1'b0;
      r_col_idx   <= '0;
      r_row_idx   <= '0;
    end else if (en) begin
      if (w_accept) begin
        // Column counter and row-triplet bookkeeping
        if (r_col_cnt == LAST_COL) begin
          r_col_cnt <= '0;
          if (r_row_cnt == LAST_ROW) begin
            r_state <= DRAIN;
          end else begin
            r_row_cnt <= r_row_cnt + CNT_W'(1);
            r_state   <= FILL;
          end
        end else begin
          r_col_cnt <= r_col_cnt + CNT_W'(1);
          if (r_col_cnt == FIRST_COL - CNT_W'(1)) begin
            r_state <= STREAM;
          end
        end
        // A new window appears once enough columns of this row are held;
        // during fill the previous window (if any) is being consumed now.
        if (r_col_cnt >= FIRST_COL) begin
          r_win_valid <= 1'b1;
          r_col_idx   <= r_col_cnt - FIRST_COL;
          r_row_idx   <= r_row_cnt;
        end else begin
          r_win_valid <= 1'b0;
        end
      end else if (w_pad_beat) begin
        // Zero column shifted in: the row's last (right-padded) window.
        // Row tag stays with the row that just finished.
        r_win_valid <= 1'b1;
        r_col_idx   <= LAST_COL;
      end else if (w_consume) begin
        r_win_valid <= 1'b0;
        if (r_state == DRAIN) begin
          r_state   <= FILL;
          r_row_cnt <= '0;
        end
      end
    end
  end

  assign win_valid = r_win_valid;
  assign col_idx   = r_col_idx;
  assign row_idx   = r_row_idx;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed testbench for conv_window_gen.
// Pixel at image (row, col) is (row*32 + col) mod 256. Expected windows are
// built from that formula; position tags follow a simple window counter.
module tb_conv_window_gen;

  localparam int IMG_W = 32;
  localparam int IMG_H = 32;
  localparam int NTRIP = IMG_H - 2;

`ifdef WIN_ZERO_PAD_EN
  localparam int C_OFF     = 1;
  localparam int WPR       = IMG_W;
  localparam int FIRST_ACC = 2;
  localparam int EXP_CTR   = 32;
`else
  localparam int C_OFF     = 0;
  localparam int WPR       = IMG_W - 2;
  localparam int FIRST_ACC = 3;
  localparam int EXP_CTR   = 33;
`endif
  localparam int TOTAL = WPR * NTRIP;

  logic        sys_clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x1, x2, x3;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win;
  logic [4:0]  col_idx;
  logic [4:0]  row_idx;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream column pointer and expected-window pointer
  int t_row, t_col;
  int e_row, e_col;

  // Outputs captured in the current cycle
  logic        cap_wv, cap_ir, cap_fd;
  logic [71:0] cap_win;
  logic [4:0]  cap_col, cap_row;
  int          cap_trow, cap_tcol;

  conv_window_gen dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win        (win),
    .col_idx    (col_idx),
    .row_idx    (row_idx),
    .frame_done (frame_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] pix(input int r, input int c);
    int v;
    v = r * 32 + c;
    return v[7:0];
  endfunction

  // Window for row triplet r, window number k within the row
  function automatic logic [71:0] exp_win(input int r, input int k);
    logic [71:0] w;
    int col;
    w = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        col = k + cc - C_OFF;
        if (col >= 0 && col < IMG_W) w[(rr*3+cc)*8 +: 8] = pix(r + rr, col);
      end
    end
    return w;
  endfunction

  task automatic sb_advance();
    e_col++;
    if (e_col == WPR) begin
      e_col = 0;
      e_row++;
      if (e_row == NTRIP) e_row = 0;
    end
  endtask

  // One clock: drive inputs at negedge, sample at negedge+1, commit at posedge
  task automatic step(input logic e, input logic iv, input logic wr,
                      output logic a, output logic c, output logic f);
    @(negedge sys_clk);
    en        = e;
    in_valid  = iv;
    win_ready = wr;
    x1 = pix(t_row,     t_col);
    x2 = pix(t_row + 1, t_col);
    x3 = pix(t_row + 2, t_col);
    #1;
    a        = in_valid & in_ready;
    c        = en & win_valid & win_ready;
    f        = frame_done;
    cap_wv   = win_valid;
    cap_ir   = in_ready;
    cap_fd   = frame_done;
    cap_win  = win;
    cap_col  = col_idx;
    cap_row  = row_idx;
    cap_trow = t_row;
    cap_tcol = t_col;
    @(posedge sys_clk);
    if (a) begin
      t_col++;
      if (t_col == IMG_W) begin
        t_col = 0;
        t_row++;
        if (t_row == NTRIP) t_row = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    in_valid  = 1'b0;
    win_ready = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst   = 1'b0;
    t_row = 0; t_col = 0;
    e_row = 0; e_col = 0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
    x1 = 8'h11; x2 = 8'h22; x3 = 8'h33;
    #1;
    n_checks++;
    if ({win_valid, frame_done, in_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/done/ready=%b expected 000", {win_valid, frame_done, in_ready});
    end
    n_checks++;
    if (win !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_win: got %h expected 0", win);
    end
    n_checks++;
    if ({col_idx, row_idx} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_idx: got col=%0d row=%0d expected 0/0", col_idx, row_idx);
    end
    @(negedge sys_clk);
    rst = 1'b0; in_valid = 1'b0;
    t_row = 0; t_col = 0; e_row = 0; e_col = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: got %b expected 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_first_window();
    logic a, c, f;
    int n_acc;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < FIRST_ACC - 1; i++) begin
      step(1, 1, 0, a, c, f);
      if (a) n_acc++;
    end
    // Column that completes the first window: nothing visible yet
    step(1, 1, 0, a, c, f);
    n_checks++;
    if (cap_wv !== 1'b0 || a !== 1'b1) begin
      n_fail++;
      $display("FAIL first_pre: got valid=%b accept=%b expected 0/1", cap_wv, a);
    end
    step(1, 1, 0, a, c, f);
    n_checks++;
    if (cap_wv !== 1'b1 || cap_ir !== 1'b0) begin
      n_fail++;
      $display("FAIL first_valid: got valid=%b ready=%b expected 1/0", cap_wv, cap_ir);
    end
    n_checks++;
    if (cap_win[7:0] !== 8'd0 || cap_win[39:32] !== 8'(EXP_CTR)) begin
      n_fail++;
      $display("FAIL first_taps: got tap0=%0d centre=%0d expected 0/%0d", cap_win[7:0], cap_win[39:32], EXP_CTR);
    end
    n_checks++;
    if (cap_win !== exp_win(0, 0) || cap_col !== 5'd0 || cap_row !== 5'd0) begin
      n_fail++;
      $display("FAIL first_win: got win=%h col=%0d row=%0d expected win=%h col=0 row=0", cap_win, cap_col, cap_row, exp_win(0, 0));
    end
    $display("test_first_window done");
  endtask

  task automatic test_full_frame();
    logic a, c, f;
    int n_win, n_fd;
    do_reset();
    n_win = 0; n_fd = 0;
    for (int i = 0; i < 3000 && n_fd == 0; i++) begin
      step(1, 1, 1, a, c, f);
      if (c) begin
        n_checks++;
        if (cap_win !== exp_win(e_row, e_col) || cap_col !== 5'(e_col) || cap_row !== 5'(e_row)) begin
          n_fail++;
          $display("FAIL frame_win: got row=%0d col=%0d win=%h expected row=%0d col=%0d win=%h", cap_row, cap_col, cap_win, e_row, e_col, exp_win(e_row, e_col));
        end
        sb_advance();
        n_win++;
      end
      if (f) begin
        n_fd++;
        n_checks++;
        if (n_win !== TOTAL || c !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_done_pos: got at window %0d (handshake=%b) expected window %0d", n_win, c, TOTAL);
        end
      end
    end
    n_checks++;
    if (n_fd !== 1 || n_win !== TOTAL) begin
      n_fail++;
      $display("FAIL frame_count: got windows=%0d done_pulses=%0d expected %0d/1", n_win, n_fd, TOTAL);
    end
    $display("test_full_frame windows=%0d", n_win);
  endtask

  task automatic test_stall();
    logic a, c, f;
    int n_win;
    do_reset();
    for (int i = 0; i < 200 && e_col < 8; i++) begin
      step(1, 1, 1, a, c, f);
      if (c) sb_advance();
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, a, c, f);
      n_checks++;
      if (cap_wv !== 1'b1 || cap_ir !== 1'b0 || a !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hs[%0d]: got valid=%b ready=%b accept=%b expected 1/0/0", i, cap_wv, cap_ir, a);
      end
      n_checks++;
      if (cap_win !== exp_win(e_row, e_col) || cap_col !== 5'(e_col)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got col=%0d win=%h expected col=%0d win=%h", i, cap_col, cap_win, e_col, exp_win(e_row, e_col));
      end
    end
    n_win = 0;
    for (int i = 0; i < 200 && n_win < 30; i++) begin
      step(1, 1, 1, a, c, f);
      if (c) begin
        n_checks++;
        if (cap_win !== exp_win(e_row, e_col) || cap_col !== 5'(e_col) || cap_row !== 5'(e_row)) begin
          n_fail++;
          $display("FAIL stall_resume: got row=%0d col=%0d win=%h expected row=%0d col=%0d win=%h", cap_row, cap_col, cap_win, e_row, e_col, exp_win(e_row, e_col));
        end
        sb_advance();
        n_win++;
      end
    end
    n_checks++;
    if (n_win !== 30) begin
      n_fail++;
      $display("FAIL stall_timeout: got %0d windows expected 30", n_win);
    end
    $display("test_stall done");
  endtask

  task automatic test_enable();
    logic a, c, f;
    int n_win;
    int hold_tcol;
    do_reset();
    for (int i = 0; i < 200 && e_col < 12; i++) begin
      step(1, 1, 1, a, c, f);
      if (c) sb_advance();
    end
    hold_tcol = t_col;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, a, c, f);
      n_checks++;
      if (cap_ir !== 1'b0 || cap_wv !== 1'b1 || t_col !== hold_tcol) begin
        n_fail++;
        $display("FAIL en_freeze[%0d]: got ready=%b valid=%b upstream_col=%0d expected 0/1/%0d", i, cap_ir, cap_wv, t_col, hold_tcol);
      end
      n_checks++;
      if (cap_win !== exp_win(e_row, e_col) || cap_col !== 5'(e_col) || cap_row !== 5'(e_row)) begin
        n_fail++;
        $display("FAIL en_hold[%0d]: got row=%0d col=%0d win=%h expected row=%0d col=%0d win=%h", i, cap_row, cap_col, cap_win, e_row, e_col, exp_win(e_row, e_col));
      end
    end
    n_win = 0;
    for (int i = 0; i < 100 && n_win < 5; i++) begin
      step(1, 1, 1, a, c, f);
      if (c) begin
        n_checks++;
        if (cap_win !== exp_win(e_row, e_col) || cap_col !== 5'(e_col) || cap_row !== 5'(e_row)) begin
          n_fail++;
          $display("FAIL en_resume: got row=%0d col=%0d win=%h expected row=%0d col=%0d win=%h", cap_row, cap_col, cap_win, e_row, e_col, exp_win(e_row, e_col));
        end
        sb_advance();
        n_win++;
      end
    end
    n_checks++;
    if (n_win !== 5) begin
      n_fail++;
      $display("FAIL en_timeout: got %0d windows expected 5", n_win);
    end
    $display("test_enable done");
  endtask

  task automatic test_reset_mid();
    logic a, c, f;
    bit hit, got;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      step(1, 1, 1, a, c, f);
      if (a && cap_trow == 3 && cap_tcol == 17) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midrst_reach: got no accept of column 17 in triplet 3 expected one");
    end
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({win_valid, frame_done, in_ready} !== 3'b000 || win !== 72'h0 || {col_idx, row_idx} !== 10'h0) begin
      n_fail++;
      $display("FAIL midrst_out: got valid=%b done=%b ready=%b win=%h col=%0d row=%0d expected all 0", win_valid, frame_done, in_ready, win, col_idx, row_idx);
    end
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      step(1, 1, 1, a, c, f);
      if (c) begin
        got = 1'b1;
        n_checks++;
        if (cap_win !== exp_win(0, 0) || cap_col !== 5'd0 || cap_row !== 5'd0) begin
          n_fail++;
          $display("FAIL midrst_first: got row=%0d col=%0d win=%h expected row=0 col=0 win=%h", cap_row, cap_col, cap_win, exp_win(0, 0));
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL midrst_timeout: got no window expected one");
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; win_ready = 1'b0;
    x1 = '0; x2 = '0; x3 = '0;
    t_row = 0; t_col = 0; e_row = 0; e_col = 0;
    test_reset();
    test_first_window();
    test_full_frame();
    test_stall();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
